// File: rtl/ds1302_txn_sched.sv
// ds1302_txn_sched: arbitrates DS1302 set-time writes against read polls and sequences byte transactions
module ds1302_txn_sched #(
  parameter int unsigned POLL_CYCLES    = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        poll_en,
  input  logic        set_req,
  input  logic        rd_req,
  input  logic [47:0] set_time,
  output logic        wr_start,
  output logic [7:0]  wr_ctrl,
  output logic [7:0]  wr_byte,
  input  logic        wr_done,
  output logic        rd_start,
  output logic [7:0]  rd_ctrl,
  input  logic [7:0]  rd_byte,
  input  logic        rd_done,
  output logic        sel_wr,
  output logic        busy,
  output logic        set_ack,
  output logic        time_valid,
  output logic [47:0] time_out,
  output logic        err
);
  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, DONE_WR, RD_ISSUE, RD_WAIT, DONE_RD} state_t;
  state_t state_q;
  logic [PW-1:0] poll_q;
  logic [TW-1:0] to_q;
  logic [2:0] idx_q;
  logic set_pend_q, rd_pend_q, poll_pend_q, err_q;
  logic [47:0] set_sh_q, time_q;
  logic [39:0] rd_sh_q;
  logic [7:0] wr_ctrl_q, wr_byte_q, rd_ctrl_q;
  logic poll_hit, to_hit;
  logic [47:0] set_sh_d;
  function automatic logic [15:0] wr_item(input logic [2:0] n, input logic [47:0] t);
    logic [47:0] s;
    s = t >> {3'd6 - n, 3'b000};
    return (n == 3'd0) ? 16'h8E00 :
           (n == 3'd7) ? 16'h8E80 :
           (n == 3'd1) ? {8'h8C, s[7:0]} :
           {8'h8C - {4'd0, n, 1'b0}, (n == 3'd6) ? {1'b0, s[6:0]} : s[7:0]};
  endfunction
  function automatic logic [7:0] rd_item(input logic [2:0] n);
    return (n == 3'd0) ? 8'h8D : 8'h8B - {4'd0, n, 1'b0};
  endfunction
  assign poll_hit = poll_en && (poll_q == POLL_LAST);
  assign to_hit = (to_q == TO_LAST);
  // later set requests overwrite the shadow, so bytes not yet issued pick up the newest fields
  assign set_sh_d = set_req ? set_time : set_sh_q;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      poll_q <= '0;
      to_q <= '0;
      idx_q <= '0;
      set_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      poll_pend_q <= 1'b0;
      err_q <= 1'b0;
      set_sh_q <= '0;
      time_q <= '0;
      rd_sh_q <= '0;
      wr_ctrl_q <= '0;
      wr_byte_q <= '0;
      rd_ctrl_q <= '0;
    end else begin
      err_q <= 1'b0;
      poll_q <= (poll_en && !poll_hit) ? poll_q + 1'b1 : '0;
      set_sh_q <= set_sh_d;
      set_pend_q <= set_pend_q | set_req;
      rd_pend_q <= rd_pend_q | rd_req;
      poll_pend_q <= poll_pend_q | poll_hit;
      case (state_q)
        IDLE: begin
          idx_q <= '0;
          if (set_pend_q) begin
            state_q <= WR_ISSUE;
            {wr_ctrl_q, wr_byte_q} <= wr_item(3'd0, set_sh_d);
            set_pend_q <= set_req;
          end else if (rd_pend_q || poll_pend_q) begin
            state_q <= RD_ISSUE;
            rd_ctrl_q <= rd_item(3'd0);
            rd_pend_q <= rd_req;
            poll_pend_q <= poll_hit;
          end
        end
        WR_ISSUE, RD_ISSUE: begin
          state_q <= (state_q == WR_ISSUE) ? WR_WAIT : RD_WAIT;
          to_q <= '0;
        end
        WR_WAIT: begin
          if (wr_done) begin
            idx_q <= idx_q + 3'd1;
            state_q <= (idx_q == 3'd7) ? DONE_WR : WR_ISSUE;
            {wr_ctrl_q, wr_byte_q} <= wr_item(idx_q + 3'd1, set_sh_d);
          end else if (to_hit) begin
            state_q <= IDLE;
            err_q <= 1'b1;
            set_pend_q <= 1'b1;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        RD_WAIT: begin
          if (rd_done) begin
            idx_q <= idx_q + 3'd1;
            rd_sh_q <= {rd_sh_q[31:0], rd_byte};
            rd_ctrl_q <= rd_item(idx_q + 3'd1);
            state_q <= (idx_q == 3'd5) ? DONE_RD : RD_ISSUE;
            if (idx_q == 3'd5) time_q <= {rd_sh_q, rd_byte};
          end else if (to_hit) begin
            state_q <= IDLE;
            err_q <= 1'b1;
            rd_pend_q <= 1'b1;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign wr_start = (state_q == WR_ISSUE);
  assign rd_start = (state_q == RD_ISSUE);
  assign sel_wr = (state_q == WR_ISSUE) || (state_q == WR_WAIT) || (state_q == DONE_WR);
  assign busy = (state_q != IDLE);
  assign set_ack = (state_q == DONE_WR);
  assign time_valid = (state_q == DONE_RD);
  assign time_out = time_q;
  assign err = err_q;
  assign wr_ctrl = wr_ctrl_q;
  assign wr_byte = wr_byte_q;
  assign rd_ctrl = rd_ctrl_q;
endmodule

// File: tb/tb_ds1302_txn_sched.sv
// tb_ds1302_txn_sched: engine responders plus table-driven, random and corner-case checks of the scheduler
module tb_ds1302_txn_sched;
  localparam int POLL = 100;
  localparam int TMO = 32;
  logic clk = 1'b0, rst = 1'b1, poll_en = 1'b0, set_req = 1'b0, rd_req = 1'b0;
  logic [47:0] set_time = '0;
  logic wr_start, rd_start, sel_wr, busy, set_ack, time_valid, err;
  logic [7:0] wr_ctrl, wr_byte, rd_ctrl;
  logic wr_done = 1'b0, rd_done = 1'b0;
  logic [7:0] rd_byte = '0;
  logic [47:0] time_out;

  always #5 clk = ~clk;

  ds1302_txn_sched #(.POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk(clk), .sys_rst(rst), .poll_en(poll_en), .set_req(set_req), .rd_req(rd_req),
    .set_time(set_time), .wr_start(wr_start), .wr_ctrl(wr_ctrl), .wr_byte(wr_byte),
    .wr_done(wr_done), .rd_start(rd_start), .rd_ctrl(rd_ctrl), .rd_byte(rd_byte),
    .rd_done(rd_done), .sel_wr(sel_wr), .busy(busy), .set_ack(set_ack),
    .time_valid(time_valid), .time_out(time_out), .err(err)
  );

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // reference: the DS1302 register map written out as plain tables
  function automatic logic [15:0] exp_wr(input int i, input logic [47:0] t);
    logic [7:0] ctl [8];
    logic [7:0] f [6];
    logic [7:0] d;
    ctl = '{8'h8E, 8'h8C, 8'h88, 8'h86, 8'h84, 8'h82, 8'h80, 8'h8E};
    for (int k = 0; k < 6; k++) f[k] = t[47-8*k -: 8];
    if (i == 0) d = 8'h00;
    else if (i == 7) d = 8'h80;
    else if (i == 6) d = f[5] & 8'h7F;
    else d = f[i-1];
    return {ctl[i], d};
  endfunction
  function automatic logic [7:0] exp_rd(input int i);
    logic [7:0] ctl [6];
    ctl = '{8'h8D, 8'h89, 8'h87, 8'h85, 8'h83, 8'h81};
    return ctl[i];
  endfunction
  function automatic logic [7:0] rd_val(input logic [7:0] c, input logic [47:0] t);
    case (c)
      8'h8D: return t[47:40];
      8'h89: return t[39:32];
      8'h87: return t[31:24];
      8'h85: return t[23:16];
      8'h83: return t[15:8];
      8'h81: return t[7:0];
      default: return 8'hEE;
    endcase
  endfunction

  int cyc = 0, wcnt = 0, rcnt = 0, dly = 2;
  int stall_cyc = 0, err_cyc = 0, ack_cyc = 0, ack_cnt = 0, tv_cnt = 0, err_cnt = 0;
  bit stall_armed = 0, prev_ws = 0, prev_rs = 0;
  logic [7:0] rcur = '0;
  logic [47:0] rd_time = '0, tv_val = '0;
  logic [15:0] wq[$];
  logic [7:0] rq[$];
  int rcq[$];
  int pq[$];

  // write/read engine models: done after dly cycles, read data looked up by register address
  initial forever begin
    @(negedge clk);
    cyc++;
    wr_done = 1'b0;
    rd_done = 1'b0;
    if (wcnt > 0) begin
      wcnt--;
      if (wcnt == 0) wr_done = 1'b1;
    end
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        rd_done = 1'b1;
        rd_byte = rd_val(rcur, rd_time);
      end
    end
    if (wr_start) begin
      wq.push_back({wr_ctrl, wr_byte});
      wcnt = dly;
      chk("sel_wr_on_wr", sel_wr, 1);
      chk("wr_start_1cyc", prev_ws, 0);
    end
    if (rd_start) begin
      rq.push_back(rd_ctrl);
      rcq.push_back(cyc);
      if (rd_ctrl == 8'h8D) pq.push_back(cyc);
      rcur = rd_ctrl;
      chk("sel_wr_on_rd", sel_wr, 0);
      chk("rd_start_1cyc", prev_rs, 0);
      if (stall_armed && rd_ctrl == 8'h85) begin
        stall_armed = 0;
        stall_cyc = cyc;
      end else rcnt = dly;
    end
    prev_ws = wr_start;
    prev_rs = rd_start;
    if (set_ack) begin ack_cnt++; ack_cyc = cyc; end
    if (time_valid) begin tv_cnt++; tv_val = time_out; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (rst) begin wcnt = 0; rcnt = 0; end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clear_logs;
    wq.delete(); rq.delete(); rcq.delete(); pq.delete();
    ack_cnt = 0; tv_cnt = 0; err_cnt = 0;
  endtask
  task automatic wait_idle(input string nm);
    int q = 0;
    for (int i = 0; i < 3000 && q < 4; i++) begin
      @(negedge clk);
      q = busy ? 0 : q + 1;
    end
    chk({nm, "_idle"}, q >= 4, 1);
  endtask

  task automatic run_txn(input bit is_set, input logic [47:0] tm, input int d,
                         input logic [47:0] exp_time, input string nm);
    clear_logs();
    dly = d;
    rd_time = tm;
    if (is_set) begin set_time = tm; set_req = 1'b1; end
    else rd_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
    rd_req = 1'b0;
    chk({nm, "_lat1"}, is_set ? wr_start : rd_start, 0);
    @(negedge clk);
    chk({nm, "_lat2"}, is_set ? wr_start : rd_start, 1);
    wait_idle(nm);
    if (is_set) begin
      chk({nm, "_nwr"}, wq.size(), 8);
      for (int i = 0; i < 8 && i < wq.size(); i++)
        chk($sformatf("%s_wr%0d", nm, i), wq[i], exp_wr(i, tm));
      chk({nm, "_ack"}, ack_cnt, 1);
      chk({nm, "_nrd"}, rq.size(), 0);
    end else begin
      chk({nm, "_nrd"}, rq.size(), 6);
      for (int i = 0; i < 6 && i < rq.size(); i++)
        chk($sformatf("%s_rd%0d", nm, i), rq[i], exp_rd(i));
      chk({nm, "_tv"}, tv_cnt, 1);
      chk({nm, "_tvval"}, tv_val, tm);
      chk({nm, "_nwr"}, wq.size(), 0);
    end
    chk({nm, "_err"}, err_cnt, 0);
    chk({nm, "_time"}, time_out, exp_time);
  endtask

  typedef struct {
    bit          is_set;
    logic [47:0] tm;
    int          d;
    logic [47:0] exp_time;
  } vec_t;

  initial begin
    vec_t tab[5];
    logic [47:0] cur_time, prev;
    logic [63:0] r;
    bit s;
    tab[0] = '{1'b1, 48'h23_07_29_12_08_95, 20, 48'h0};
    tab[1] = '{1'b0, 48'h23_07_29_12_08_15, 2, 48'h23_07_29_12_08_15};
    tab[2] = '{1'b1, 48'h99_12_31_23_59_D9, 1, 48'h23_07_29_12_08_15};
    tab[3] = '{1'b0, 48'h00_01_01_00_00_00, 5, 48'h00_01_01_00_00_00};
    tab[4] = '{1'b0, 48'hFF_FF_FF_FF_FF_FF, 1, 48'hFF_FF_FF_FF_FF_FF};
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_busy", busy, 0);
    chk("rst_sel_wr", sel_wr, 0);
    chk("rst_wr_start", wr_start, 0);
    chk("rst_rd_start", rd_start, 0);
    chk("rst_set_ack", set_ack, 0);
    chk("rst_time_valid", time_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_time_out", time_out, 0);
    chk("rst_wr_ctrl", {wr_ctrl, wr_byte, rd_ctrl}, 0);

    for (int i = 0; i < 5; i++)
      run_txn(tab[i].is_set, tab[i].tm, tab[i].d, tab[i].exp_time, $sformatf("vec%0d", i));
    cur_time = tab[4].exp_time;

    for (int i = 0; i < 10; i++) begin
      s = 1'($urandom_range(0, 1));
      r = {$urandom, $urandom};
      if (!s) cur_time = r[47:0];
      run_txn(s, r[47:0], int'($urandom_range(1, 8)), cur_time, $sformatf("rnd%0d", i));
    end

    // periodic polling: intervals between read sequences, then silence once disabled
    clear_logs();
    dly = 1;
    rd_time = 48'h24_02_29_23_59_58;
    poll_en = 1'b1;
    for (int i = 0; i < 600 && pq.size() < 4; i++) tick(1);
    chk("t3_polls", pq.size() >= 4, 1);
    for (int k = 1; k < 4 && k < pq.size(); k++)
      chk($sformatf("t3_interval%0d", k), pq[k] - pq[k-1], POLL);
    tick(30);
    chk("t3_time", time_out, rd_time);
    poll_en = 1'b0;
    clear_logs();
    tick(300);
    chk("t3_stopped", rq.size(), 0);
    chk("t3_err", err_cnt, 0);

    // set_req in the same cycle as poll expiry
    clear_logs();
    dly = 1;
    set_time = 48'h25_01_02_03_04_05;
    rd_time = 48'h25_01_02_03_04_06;
    poll_en = 1'b1;
    tick(99);
    set_req = 1'b1;
    tick(1);
    set_req = 1'b0;
    for (int i = 0; i < 300 && tv_cnt == 0; i++) tick(1);
    poll_en = 1'b0;
    wait_idle("t4");
    chk("t4_nwr", wq.size(), 8);
    chk("t4_nrd", rq.size(), 6);
    chk("t4_ack", ack_cnt, 1);
    chk("t4_tv", tv_cnt, 1);
    chk("t4_err", err_cnt, 0);
    chk("t4_wr1", wq.size() > 1 ? wq[1] : 16'h0, exp_wr(1, set_time));
    chk("t4_gap", rcq.size() > 0 ? rcq[0] - ack_cyc : -1, 2);
    chk("t4_time", tv_val, rd_time);

    // engine timeout on read byte 3, then automatic retry from the first register
    clear_logs();
    dly = 2;
    prev = time_out;
    rd_time = 48'h11_22_33_44_55_66;
    stall_armed = 1;
    rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
    for (int i = 0; i < 300 && err_cnt == 0; i++) tick(1);
    chk("t5_err", err_cnt, 1);
    chk("t5_keep", time_out, prev);
    chk("t5_tmo", err_cyc - stall_cyc, TMO + 1);
    wait_idle("t5");
    chk("t5_nrd", rq.size(), 10);
    chk("t5_stalled", rq.size() > 3 ? rq[3] : 8'h0, 8'h85);
    chk("t5_retry", rq.size() > 4 ? rq[4] : 8'h0, 8'h8D);
    chk("t5_retry_gap", rcq.size() > 4 ? rcq[4] - err_cyc : -1, 1);
    chk("t5_tv", tv_cnt, 1);
    chk("t5_time", time_out, rd_time);
    chk("t5_err_total", err_cnt, 1);

    // reset while waiting on write byte 4
    clear_logs();
    dly = 20;
    set_time = 48'h24_12_31_23_59_59;
    set_req = 1'b1;
    tick(1);
    set_req = 1'b0;
    for (int i = 0; i < 400 && wq.size() < 5; i++) tick(1);
    tick(2);
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_ctrl", wr_ctrl, 8'h84);
    rst = 1'b1;
    tick(1);
    chk("t6_busy", busy, 0);
    chk("t6_sel_wr", sel_wr, 0);
    chk("t6_starts", {wr_start, rd_start}, 0);
    chk("t6_pulses", {set_ack, time_valid, err}, 0);
    chk("t6_bytes", {wr_ctrl, wr_byte, rd_ctrl}, 0);
    chk("t6_time", time_out, 0);
    tick(1);
    rst = 1'b0;
    clear_logs();
    tick(80);
    chk("t6_no_wr", wq.size(), 0);
    chk("t6_no_ack", ack_cnt, 0);
    chk("t6_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
